// File: rtl/ped_input_conditioner.sv
// Pad-input front end for the traffic light controller: synchronises and debounces the
// on/off switch and both pedestrian buttons, and latches pedestrian requests until acknowledged.
module ped_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       light_on_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       ped_ack,
  output logic       light_on,
  output logic       ped_req,
  output logic       req_left,
  output logic       req_right,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order in the vectors below: [0] switch, [1] left button, [2] right button.
  logic [2:0]       raw;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       stable;
  logic [1:0]       btn_prev;
  logic [CNT_W-1:0] cnt [3];
  logic             press_left;
  logic             press_right;

  assign raw = {btn_right_raw, btn_left_raw, light_on_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Any disagreement between the synced level and the stable level must persist for
  // DEBOUNCE_CYCLES cycles in a row; a single agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= '0;
      btn_prev <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      btn_prev <= stable[2:1];
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign light_on    = stable[0];
  assign press_left  = stable[1] & ~btn_prev[0];
  assign press_right = stable[2] & ~btn_prev[1];

  // ped_ack is a one-cycle pulse with no back-pressure; a press in the same cycle wins,
  // so the ack only clears requests that were already being served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_left  <= 1'b0;
      req_right <= 1'b0;
    end else begin
      if (!light_on)       req_left <= 1'b0;
      else if (press_left) req_left <= 1'b1;
      else if (ped_ack)    req_left <= 1'b0;

      if (!light_on)        req_right <= 1'b0;
      else if (press_right) req_right <= 1'b1;
      else if (ped_ack)     req_right <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_cnt <= 8'd0;
    end else if (light_on && (press_left || press_right) && (press_cnt != 8'hFF)) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end

  assign ped_req = req_left | req_right;

endmodule

// File: doc/ped_input_conditioner.md
Name: ped_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the traffic light controller FSM.
- Takes the raw pad inputs: the on/off switch and the left and right pedestrian push buttons.
- Synchronises and debounces them, and turns button presses into latched pedestrian requests.
- Holds each request until the controller acknowledges that the pedestrian phase was granted, so no press is lost between FSM states.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive stable clock cycles required before a debounced level changes. 20 ms at the 1 kHz sim clock; set 20000 for the 1 MHz clock.
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- light_on_raw  input  1  raw on/off switch (ui_in[0])
- btn_left_raw  input  1  raw left pedestrian button (ui_in[1]), active-high
- btn_right_raw  input  1  raw right pedestrian button (ui_in[2]), active-high
- ped_ack  input  1  one-cycle pulse from controller: pedestrian phase granted
- light_on  output  1  debounced on/off level to controller
- ped_req  output  1  req_left OR req_right
- req_left  output  1  latched left request (also drives the "wait" indicator)
- req_right  output  1  latched right request
- press_cnt  output  8  accepted-press counter, saturating, debug

Behaviour:
- Reset (async, active-high, allowed at any time, including mid-debounce or mid-request):
  - All synchroniser flops, debounced levels, counters, request latches and press_cnt go to 0 immediately.
  - All outputs are 0 while rst is high.
- Synchroniser: 2-flop chain per raw input. Raw values are used nowhere else.
- Debounce, per channel, with state {stable, cnt}:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - sync != stable otherwise: cnt <= cnt+1.
  - Latency from a raw edge to the debounced edge is exactly 2+DEBOUNCE_CYCLES clock edges.
  - A pulse or glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
  - Bounce restarts the count from 0.
- light_on = debounced switch level.
- Press event: 1-cycle internal pulse on the rising edge of a debounced button (previous stable 0, new stable 1).
  - A held button gives exactly one press.
  - Release gives nothing.
- Request latches, per side, with priority (highest first):
  1. light_on == 0: clear, press ignored.
  2. Press event: set.
  3. ped_ack: clear.
- Consequences of the priority order:
  - A press coinciding with ped_ack keeps that side's request set; no press is lost.
  - ped_ack clears both sides, since one pedestrian phase serves both crossings.
  - A press while the side is already requested leaves the latch at 1 (idempotent).
- Simultaneous left and right presses set both latches in the same cycle.
- press_cnt:
  - Increments by 1 per cycle in which at least one accepted press occurs (light_on == 1). Simultaneous left and right count as 1.
  - Saturates at 255; no wrap.
  - Cleared only by rst.
- ped_ack while no request is pending: no effect.
- Outputs are registered (req_*, light_on, press_cnt). ped_req is the OR of registered bits.
- Visible latency: a request appears on the edge after the debounced rising edge, i.e. 3+DEBOUNCE_CYCLES edges after the raw press.

Test Plan:
- DEBOUNCE_CYCLES=4. Assert rst mid-count with btn_left high for 3 cycles -> all outputs 0 immediately; after release no request; cnt restarts from 0.
- light_on_raw 0->1 -> light_on rises exactly 6 edges later. Toggle raw for 3 cycles -> light_on unchanged.
- light_on=1, btn_left_raw high 10 cycles -> req_left=1 and ped_req=1 at edge 7; press_cnt=1; holding longer gives no second count. Pulse ped_ack -> req_left=0 next edge.
- Bouncy right press (1,0,1,0 then steady 1) -> single request, press_cnt increments by 1. Left press whose rising edge lands in the same cycle as ped_ack -> req_left stays 1.
- Both buttons pressed in the same cycle -> req_left=req_right=1, press_cnt +1. Then switch off -> both requests clear once light_on falls; presses while off are ignored and not counted.
- 300 separated presses -> press_cnt saturates at 255.
